// File: rtl/pe27_postproc_if.sv
// rtl/pe27_postproc_if.sv - MAC-result input and int8 activation output handshake bundle
interface pe27_postproc_if;
  logic        mac_valid;
  logic [23:0] mac_in;
  logic [23:0] bias;
  logic [4:0]  shift;
  logic        mac_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  mac_valid, mac_in, bias, shift, out_ready,
    output mac_ready, out_data, out_valid
  );

  modport master (
    output mac_valid, mac_in, bias, shift, out_ready,
    input  mac_ready, out_data, out_valid
  );
endinterface

// File: rtl/pe27_postproc.sv
// rtl/pe27_postproc.sv - bias/ReLU/requant/saturate pipeline feeding an int8 output FIFO
// Optional: define PE27_LEAKY_RELU_EN for a 1/8-slope leaky ReLU instead of plain ReLU.
module pe27_postproc #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pe27_postproc_if.slave     bus,
  output logic               sat_flag,
  output logic               drop_err,
  input  logic               err_clr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic               s1_v;
  logic signed [24:0] s1_sum;
  logic [4:0]         s1_shift;
  logic               s2_v;
  logic [7:0]         s2_data;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [OW-1:0]      occupancy;

  logic               accept;
  logic               push;
  logic               pop;

  logic signed [24:0] act;
  logic [4:0]         s_eff;
  logic [25:0]        rnd;
  logic signed [25:0] shifted;
  logic [7:0]         sat_val;
  logic               clip;

  // In-flight pipeline slots count against capacity so a push can never find the FIFO full.
  assign occupancy     = OW'(count) + OW'(s1_v) + OW'(s2_v);
  assign bus.mac_ready = rst_n && (occupancy < OW'(FIFO_DEPTH));
  assign bus.out_valid = rst_n && (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 8'd0;

  assign accept = bus.mac_valid && bus.mac_ready;
  assign push   = s2_v;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    act = s1_sum;
    if (s1_sum[24]) begin
`ifdef PE27_LEAKY_RELU_EN
      act = s1_sum >>> 3;
`else
      act = '0;
`endif
    end
    s_eff   = (s1_shift > 5'd23) ? 5'd23 : s1_shift;
    rnd     = (s_eff == 5'd0) ? 26'd0 : (26'd1 << (s_eff - 5'd1));
    shifted = ($signed({act[24], act}) + $signed(rnd)) >>> s_eff;
    clip    = 1'b0;
    sat_val = shifted[7:0];
    if (shifted > 26'sd127) begin
      sat_val = 8'h7F;
      clip    = 1'b1;
    end else if (shifted < -26'sd128) begin
      sat_val = 8'h80;
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_sum   <= $signed({bus.mac_in[23], bus.mac_in}) + $signed({bus.bias[23], bus.bias});
        s1_shift <= bus.shift;
      end
      s2_v <= s1_v;
      if (s1_v) s2_data <= sat_val;
      if (push) begin
        mem[wr_ptr] <= s2_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      // A new flag event on the same edge as err_clr keeps the flag set.
      sat_flag <= (s1_v && clip) || (sat_flag && !err_clr);
      drop_err <= (bus.mac_valid && !bus.mac_ready) || (drop_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_pe27_postproc.sv
// tb/tb_pe27_postproc.sv - self-checking bench for pe27_postproc against a queue-based reference model
module tb_pe27_postproc;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic sat_flag;
  logic drop_err;
  logic err_clr;

  pe27_postproc_if bus ();

  pe27_postproc #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sat_flag (sat_flag),
    .drop_err (drop_err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit clip;
    int cyc;
  } item_t;

  item_t q[$];
  bit    m_sat;
  bit    m_drop;
  int    now;
  int    n_cmp;
  int    n_fail;

  function automatic int ref_out(input logic [23:0] mi, input logic [23:0] b,
                                 input logic [4:0] sh, output bit clp);
    int sum, a, s, r;
    sum = int'($signed(mi)) + int'($signed(b));
    a = sum;
    if (sum < 0) begin
`ifdef PE27_LEAKY_RELU_EN
      a = sum >>> 3;
`else
      a = 0;
`endif
    end
    s = (int'(sh) > 23) ? 23 : int'(sh);
    r = (s == 0) ? a : ((a + (1 << (s - 1))) >>> s);
    clp = (r > 127) || (r < -128);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic bit m_ready();
    return q.size() < DEPTH;
  endfunction

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].cyc + 2 <= now);
  endfunction

  function automatic logic [7:0] m_head();
    int d;
    d = q[0].data;
    return d[7:0];
  endfunction

  // Drives one cycle of inputs at a negedge, advances the model past the next edge, returns at the following negedge.
  task automatic step(input logic mv, input logic [23:0] mi, input logic [23:0] b,
                      input logic [4:0] sh, input logic ordy, input logic eclr);
    bit    rdy, vld, sat_evt, clp;
    item_t it;
    bus.mac_valid = mv;
    bus.mac_in    = mi;
    bus.bias      = b;
    bus.shift     = sh;
    bus.out_ready = ordy;
    err_clr       = eclr;
    rdy     = m_ready();
    vld     = m_valid();
    sat_evt = 1'b0;
    foreach (q[i]) if (q[i].cyc == now && q[i].clip) sat_evt = 1'b1;
    now++;
    if (vld && ordy) void'(q.pop_front());
    if (mv && rdy) begin
      it.data = ref_out(mi, b, sh, clp);
      it.clip = clp;
      it.cyc  = now;
      q.push_back(it);
    end
    m_sat  = sat_evt || (m_sat && !eclr);
    m_drop = (mv && !rdy) || (m_drop && !eclr);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 24'd0, 24'd0, 5'd0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got=%h want=00", bus.out_data); end
    n_cmp++; if (bus.mac_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mac_ready got=%b want=0", bus.mac_ready); end
    n_cmp++; if ({sat_flag, drop_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b want=00", sat_flag, drop_err); end
    q.delete(); m_sat = 0; m_drop = 0;
    rst_n = 1'b1;
    idle(1'b1);
    n_cmp++; if (bus.mac_ready !== 1'b1) begin n_fail++; $display("FAIL release_mac_ready got=%b want=1", bus.mac_ready); end
  endtask

  task automatic test_basic();
    step(1'b1, 24'd27, 24'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_n0 got=%b want=0", bus.out_valid); end
    idle(1'b0);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_n1 got=%b want=0", bus.out_valid); end
    idle(1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_n2 got=%b want=1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'd27) begin n_fail++; $display("FAIL basic_data got=%0d want=27", bus.out_data); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat got=%b want=0", sat_flag); end
    idle(1'b1);
  endtask

  task automatic test_requant();
    step(1'b1, 24'd54, 24'd11, 5'd2, 1'b0, 1'b0);
    step(1'b1, 24'd300, 24'd0, 5'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    n_cmp++; if (bus.out_data !== 8'd16) begin n_fail++; $display("FAIL requant_round got=%0d want=16", bus.out_data); end
    n_cmp++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL requant_sat got=%b want=1", sat_flag); end
    idle(1'b1);
    n_cmp++; if (bus.out_data !== 8'd127) begin n_fail++; $display("FAIL requant_clip got=%0d want=127", bus.out_data); end
    idle(1'b1);
    step(1'b0, 24'd0, 24'd0, 5'd0, 1'b1, 1'b1);
    n_cmp++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL requant_sat_clr got=%b want=0", sat_flag); end
  endtask

  task automatic test_relu();
    logic [7:0] want;
`ifdef PE27_LEAKY_RELU_EN
    want = 8'hF6;
`else
    want = 8'h00;
`endif
    step(1'b1, 24'hFFFFB0, 24'd0, 5'd0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    n_cmp++; if (bus.out_data !== want) begin n_fail++; $display("FAIL relu_neg got=%h want=%h", bus.out_data, want); end
    idle(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd30; vals[3] = 8'd40;
    for (int i = 0; i < 4; i++) step(1'b1, {16'd0, vals[i]}, 24'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (bus.mac_ready !== 1'b0) begin n_fail++; $display("FAIL full_mac_ready got=%b want=0", bus.mac_ready); end
    step(1'b1, 24'd99, 24'd0, 5'd0, 1'b0, 1'b0);
    n_cmp++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_set got=%b want=1", drop_err); end
    step(1'b1, 24'd98, 24'd0, 5'd0, 1'b0, 1'b1);
    n_cmp++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_beats_clr got=%b want=1", drop_err); end
    step(1'b0, 24'd0, 24'd0, 5'd0, 1'b0, 1'b1);
    n_cmp++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL drop_clr got=%b want=0", drop_err); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i]) begin
        n_fail++; $display("FAIL drain_%0d got=%b/%0d want=1/%0d", i, bus.out_valid, bus.out_data, vals[i]);
      end
      idle(1'b1);
    end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.mac_ready !== 1'b1) begin
      n_fail++; $display("FAIL drained got=v%b r%b want=v0 r1", bus.out_valid, bus.mac_ready);
    end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 24'd300, 24'd0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 24'd6, 24'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.mac_valid = 1'b0;
    #1;
    n_cmp++; if (bus.mac_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL inrst_outputs got=r%b v%b want=r0 v0", bus.mac_ready, bus.out_valid);
    end
    @(negedge clk);
    q.delete(); m_sat = 0; m_drop = 0; now++;
    rst_n = 1'b1;
    n_cmp++; if ({sat_flag, drop_err} !== 2'b00) begin n_fail++; $display("FAIL inrst_flags got=%b%b want=00", sat_flag, drop_err); end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL inrst_stale_%0d got=%b want=0", i, bus.out_valid); end
    end
    n_cmp++; if (bus.mac_ready !== 1'b1) begin n_fail++; $display("FAIL inrst_ready got=%b want=1", bus.mac_ready); end
  endtask

  task automatic test_random();
    logic [23:0] mi, b;
    for (int c = 0; c < 1500; c++) begin
      n_cmp++; if (bus.out_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, bus.out_valid, m_valid()); end
      if (m_valid()) begin
        n_cmp++; if (bus.out_data !== m_head()) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, bus.out_data, m_head()); end
      end
      n_cmp++; if (bus.mac_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, bus.mac_ready, m_ready()); end
      n_cmp++; if (sat_flag !== m_sat) begin n_fail++; $display("FAIL rnd_sat c=%0d got=%b want=%b", c, sat_flag, m_sat); end
      n_cmp++; if (drop_err !== m_drop) begin n_fail++; $display("FAIL rnd_drop c=%0d got=%b want=%b", c, drop_err, m_drop); end
      if ($urandom_range(3) == 0) mi = 24'($urandom);
      else mi = 24'($signed($urandom_range(2000)) - 1000);
      b = ($urandom_range(1) == 0) ? 24'd0 : 24'($signed($urandom_range(400)) - 200);
      step($urandom_range(1) == 1, mi, b, 5'($urandom), $urandom_range(9) < 6,
           $urandom_range(19) == 0);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; now = 0; m_sat = 0; m_drop = 0;
    rst_n = 1'b0; err_clr = 1'b0;
    bus.mac_valid = 1'b0; bus.mac_in = '0; bus.bias = '0; bus.shift = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_requant();
    test_relu();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pe27_postproc.md
PE27_POSTPROC -- requirements
Module: pe27_postproc

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port mac_valid  input  1  one-cycle pulse; connected to the 27-term MAC's done.
REQ-005 SHALL have port mac_in  input  24  MAC result, two's complement.
REQ-006 SHALL have port bias  input  24  signed bias, sampled with mac_valid.
REQ-007 SHALL have port shift  input  5  requant right-shift, sampled with mac_valid.
REQ-008 SHALL have port mac_ready  output  1  high when a new MAC result can be accepted; the controller gates start with it.
REQ-009 SHALL have port out_data  output  8  signed int8 activation at FIFO head.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_ready  input  1  consumer accept; pop when out_valid & out_ready.
REQ-012 SHALL have port sat_flag  output  1  sticky; a result was clipped.
REQ-013 SHALL have port drop_err  output  1  sticky; mac_valid arrived while mac_ready low.
REQ-014 SHALL have port err_clr  input  1  clears sat_flag and drop_err.

Function
REQ-015 SHALL use a 2-stage pipeline: S1 registers sum = sext25(mac_in)+sext25(bias) and shift; S2 registers the activated, requantised, saturated int8.
REQ-016 SHALL treat S1 sum as exact 25-bit signed with no wrap.
REQ-017 SHALL apply activation to sum: negative sum gives 0 (ReLU); non-negative sum passes through.
REQ-018 SHALL requantise as (a + (1<<(s-1))) >>> s for s>0 and a for s=0, arithmetic shift, with s = min(shift,23).
REQ-019 SHALL saturate to [-128,127] and set sat_flag on the cycle S2 loads a clipped value.
REQ-020 SHALL write the S2 result into the FIFO on the next edge: mac_valid sampled at edge N gives out_valid high after edge N+2 when the FIFO is empty.
REQ-021 SHALL preserve arrival order; out_data SHALL hold stable while out_valid & !out_ready.
REQ-022 SHALL compute occupancy = FIFO entries + valid S1 + valid S2, and SHALL drive mac_ready = (occupancy < FIFO_DEPTH), so the FIFO never overflows.
REQ-023 SHALL drop a mac_valid seen with mac_ready low, set drop_err, and leave the pipeline and FIFO unchanged.
REQ-024 SHALL allow push and pop on the same edge at any occupancy; the count is unchanged and data stays in order.
REQ-025 SHALL give a pop on an empty FIFO no effect.
REQ-026 SHALL let a flag-setting event win over err_clr on the same edge.

Reset
REQ-027 SHALL, on an edge with rst_n low, clear S1/S2 valid, the FIFO pointers and count, sat_flag and drop_err, discarding in-flight data.
REQ-028 SHALL during reset hold out_valid=0, out_data=0 and mac_ready=0; the cycle after release, mac_ready=1.

Configuration
REQ-029 SHALL, when PE27_LEAKY_RELU_EN is defined, map negative sum to sum>>>3 (slope 1/8, floor) instead of 0; all other behaviour is unchanged.
REQ-030 SHALL, without PE27_LEAKY_RELU_EN, implement plain ReLU per REQ-017.

Verification
REQ-031 SHALL cover: mac_in=27, bias=0, shift=0 -> out_data=27, out_valid 2 edges after mac_valid, sat_flag=0.
REQ-032 SHALL cover: mac_in=54, bias=11, shift=2 -> out_data=16; mac_in=300, shift=0 -> out_data=127 and sat_flag=1.
REQ-033 SHALL cover: mac_in=-80, bias=0, shift=0 -> out_data=0 without the macro; with PE27_LEAKY_RELU_EN -> out_data=0xF6 (-10).
REQ-034 SHALL cover: out_ready=0, 4 results pushed -> mac_ready=0; a 5th mac_valid sets drop_err; out_ready=1 -> the 4 values drain in order, then mac_ready=1.
REQ-035 SHALL cover: rst_n low for 1 cycle with 2 results in flight -> out_valid=0, flags cleared, no stale output after release.
